// File: rtl/ph_byte_drain.sv
// Host-side drain for the parasite-to-host byte buffer: polls the flag, strobes a read,
// and queues captured bytes into a small FIFO presented as a valid/ready stream.
module ph_byte_drain #(
  parameter int DEPTH      = 4,
  parameter int LVL_W      = 3,
  parameter int SETTLE_MAX = 8
) (
  input  logic             h_phi2,
  input  logic             h_rst_b,
  input  logic             enable,
  input  logic             h_data_available,
  input  logic [7:0]       h_data,
  output logic             h_selectData,
  output logic             h_rd,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             err_stuck
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT_CLR} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             strobe_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       mem_q [DEPTH];
  logic             push, pop;

  assign push      = (state_q == READ);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;

  assign h_selectData = strobe_q;
  assign h_rd         = strobe_q;
  assign fifo_level   = level_q;
  assign err_stuck    = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      // A full FIFO leaves the byte in the buffer, back-pressuring the parasite.
      IDLE: begin
        if (enable && h_data_available && (level_q < LVL_W'(DEPTH)))
          state_d = READ;
      end
      READ: begin
        state_d = WAIT_CLR;
        cnt_d   = '0;
      end
      WAIT_CLR: begin
        if (!h_data_available) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == 8'(SETTLE_MAX)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (!push && pop)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      strobe_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      strobe_q <= (state_d == READ);
      level_q  <= level_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the level counter gates visibility of stale entries.
  always_ff @(posedge h_phi2) begin
    if (push)
      mem_q[wr_ptr_q] <= h_data;
  end

endmodule

// File: tb/tb_ph_byte_drain.sv
// Randomised scoreboard bench for ph_byte_drain; a buffer emulator offers bytes and a
// monitor compares every delivered byte and the FIFO level against a queue model.
module tb_ph_byte_drain;
  localparam int DEPTH      = 4;
  localparam int LVL_W      = 3;
  localparam int SETTLE_MAX = 8;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             enable = 1'b0;
  logic             dav = 1'b0;
  logic [7:0]       hdata = 8'h00;
  logic             out_ready = 1'b0;
  logic             h_selectData, h_rd, out_valid, err_stuck;
  logic [7:0]       out_data;
  logic [LVL_W-1:0] fifo_level;

  always #5 clk = ~clk;

  ph_byte_drain #(.DEPTH(DEPTH), .LVL_W(LVL_W), .SETTLE_MAX(SETTLE_MAX)) dut (
    .h_phi2(clk), .h_rst_b(rst_b), .enable(enable),
    .h_data_available(dav), .h_data(hdata),
    .h_selectData(h_selectData), .h_rd(h_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .err_stuck(err_stuck)
  );

  typedef struct {
    logic [7:0] b;
    int         hold;
    int         gap;
  } tx_t;

  tx_t        tx_q[$];
  logic [7:0] exp_q[$];
  int checks = 0, failures = 0;
  int st = 0;
  int rd_cnt = 0, simul = 0, lvl_m = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Buffer emulator: offers queued bytes, holds the flag for `hold` cycles after the read.
  initial begin : emulator
    tx_t  cur;
    logic rd_s;
    int   hold_left, gap_left;
    hold_left = 0;
    gap_left  = 0;
    cur.b = 8'h00; cur.hold = 0; cur.gap = 0;
    forever begin
      @(negedge clk);
      rd_s = h_rd;
      @(posedge clk);
      #2;
      if (!rst_b) begin
        dav = 1'b0;
        st  = 0;
        gap_left = 0;
        tx_q.delete();
      end else begin
        case (st)
          0: if (tx_q.size() != 0) begin
               if (gap_left < tx_q[0].gap) gap_left++;
               else begin
                 cur = tx_q.pop_front();
                 gap_left = 0;
                 hdata = cur.b;
                 dav = 1'b1;
                 exp_q.push_back(cur.b);
                 st = 1;
               end
             end
          1: if (rd_s) begin
               hold_left = cur.hold;
               if (hold_left == 0) begin dav = 1'b0; st = 0; end
               else st = 2;
             end
          default: begin
               hold_left--;
               if (hold_left == 0) begin dav = 1'b0; st = 0; end
             end
        endcase
      end
    end
  end

  // Monitor: level = captures - accepted pops; output order = offer order.
  initial begin : monitor
    int         lvl_prev;
    logic       en_prev, dav_prev, take;
    logic [7:0] e;
    lvl_prev = 0; en_prev = 1'b0; dav_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        exp_q.delete();
        lvl_m = 0; lvl_prev = 0; en_prev = 1'b0; dav_prev = 1'b0;
      end else begin
        take = (lvl_m != 0) && out_ready;
        chk("fifo_level", int'(fifo_level), lvl_m);
        chk("out_valid", int'(out_valid), int'(lvl_m != 0));
        if (lvl_m == 0) chk("out_data_empty", int'(out_data), 0);
        if (h_rd) begin
          chk("rd_with_select", int'(h_selectData), 1);
          chk("rd_byte_unread", int'(st == 1), 1);
          chk("rd_enabled", int'(en_prev), 1);
          chk("rd_flag_seen", int'(dav_prev), 1);
          chk("rd_not_full", int'(lvl_prev < DEPTH), 1);
          rd_cnt++;
        end
        if (take) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL pop_unexpected actual=%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", int'(out_data), int'(e));
          end
        end
        if (h_rd && take) simul++;
        lvl_prev = lvl_m;
        lvl_m = lvl_m + (h_rd ? 1 : 0) - (take ? 1 : 0);
        en_prev  = enable;
        dav_prev = dav;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic offer(input logic [7:0] b, input int hold, input int gap);
    tx_t t;
    t.b = b; t.hold = hold; t.gap = gap;
    tx_q.push_back(t);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    step(1);
    while ((exp_q.size() != 0 || tx_q.size() != 0 || st != 0) && n < 3000) begin
      step(1);
      n++;
    end
    chk(name, int'(n < 3000), 1);
  endtask

  task automatic wait_rd(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (h_rd) begin ok = 1'b1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    int rd0, sim0, sent;
    repeat (2) @(negedge clk);
    chk("rst_select", int'(h_selectData), 0);
    chk("rst_rd", int'(h_rd), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_err", int'(err_stuck), 0);
    @(posedge clk); #4 rst_b = 1'b1;
    step(1);

    // single byte, flag drops right after the read
    enable = 1'b1; out_ready = 1'b0; rd0 = rd_cnt;
    offer(8'h5A, 0, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_level == 1) begin ok = 1'b1; break; end
    end
    chk("t1_captured", int'(ok), 1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 8'h5A);
    step(3);
    chk("t1_single_read", rd_cnt - rd0, 1);
    out_ready = 1'b1;
    drain("t1_drain");

    // back-pressure: fifth byte must wait in the buffer
    out_ready = 1'b0; rd0 = rd_cnt;
    for (int b = 1; b <= 5; b++) offer(8'(b), 0, 0);
    step(40);
    chk("t2_level_full", int'(fifo_level), DEPTH);
    chk("t2_reads_while_full", rd_cnt - rd0, 4);
    chk("t2_fifth_pending", st, 1);
    out_ready = 1'b1;
    drain("t2_drain");
    chk("t2_total_reads", rd_cnt - rd0, 5);

    // refill while popping: push and pop land on the same edge, pointers wrap
    out_ready = 1'b0; sim0 = simul;
    for (int b = 0; b < 4; b++) offer(8'(8'hA0 + b), 0, 0);
    offer(8'hC3, 0, 0);
    step(40);
    chk("t3_level_full", int'(fifo_level), DEPTH);
    out_ready = 1'b1;
    drain("t3_drain");
    chk("t3_push_pop_same_cycle", int'(simul > sim0), 1);

    // stuck flag: error exactly SETTLE_MAX cycles into the wait
    chk("t4_err_before", int'(err_stuck), 0);
    offer(8'h96, SETTLE_MAX, 0);
    wait_rd("t4_read");
    for (int k = 1; k <= SETTLE_MAX; k++) begin
      @(negedge clk);
      chk("t4_err_early", int'(err_stuck), 0);
    end
    @(negedge clk);
    chk("t4_err_set", int'(err_stuck), 1);
    step(1); rd0 = rd_cnt;
    offer(8'h77, 0, 0);
    drain("t4_drain");
    chk("t4_next_read", rd_cnt - rd0, 1);
    chk("t4_err_sticky", int'(err_stuck), 1);

    // enable dropped mid-read: access completes, then nothing until re-enabled
    out_ready = 1'b1;
    offer(8'h3C, 0, 0);
    wait_rd("t5_read");
    #1 enable = 1'b0;
    rd0 = rd_cnt;
    offer(8'h4D, 0, 0);
    step(20);
    chk("t5_no_read_disabled", rd_cnt - rd0, 0);
    chk("t5_pending_count", exp_q.size(), 1);
    chk("t5_level", int'(fifo_level), 0);
    enable = 1'b1;
    drain("t5_drain");
    chk("t5_read_after_enable", rd_cnt - rd0, 1);

    // reset during the wait with two bytes queued
    out_ready = 1'b0;
    offer(8'h11, 0, 0);
    offer(8'h22, 5, 0);
    wait_rd("t6_read1");
    wait_rd("t6_read2");
    @(posedge clk); #3;
    rst_b = 1'b0;
    #1;
    chk("t6_rst_select", int'(h_selectData), 0);
    chk("t6_rst_rd", int'(h_rd), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_level", int'(fifo_level), 0);
    repeat (3) @(posedge clk);
    #4 rst_b = 1'b1;
    @(negedge clk);
    chk("t6_level_after", int'(fifo_level), 0);
    chk("t6_valid_after", int'(out_valid), 0);
    chk("t6_err_cleared", int'(err_stuck), 0);
    step(1);

    // random traffic
    sent = 0;
    for (int c = 0; c < 600; c++) begin
      step(1);
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      if (sent < 60 && tx_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        offer(8'($urandom_range(0, 255)), int'($urandom_range(0, SETTLE_MAX - 1)),
              int'($urandom_range(0, 2)));
        sent++;
      end
    end
    enable = 1'b1; out_ready = 1'b1;
    drain("rand_drain");
    chk("rand_no_err", int'(err_stuck), 0);
    chk("rand_all_delivered", exp_q.size(), 0);
    chk("rand_level_empty", int'(fifo_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
